// File: rtl/vp_centroid.sv
// rtl/vp_centroid.sv - binary-object centroid tracker with crosshair overlay
// Accumulates object pixel statistics per frame and divides them at frame end.
module vp_centroid #(
  parameter int          H_SIZE     = 1280,
  parameter int          V_SIZE     = 720,
  parameter int          X_W        = 11,
  parameter int          Y_W        = 11,
  parameter int          SUM_W      = 32,
  parameter int          CNT_W      = 21,
  parameter logic [23:0] MARK_COLOR = 24'hFF0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de_in,
  input  logic             v_sync_in,
  input  logic             h_sync_in,
  input  logic [23:0]      pixel_in,
  output logic             de_out,
  output logic             v_sync_out,
  output logic             h_sync_out,
  output logic [23:0]      pixel_out,
  output logic [X_W-1:0]   centroid_x,
  output logic [Y_W-1:0]   centroid_y,
  output logic             centroid_valid,
  output logic             frame_done
);

  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

  localparam int             BIT_W    = $clog2(SUM_W);
  localparam logic [X_W-1:0] X_MAX    = X_W'(H_SIZE - 1);
  localparam logic [Y_W-1:0] Y_MAX    = Y_W'(V_SIZE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SUM_W - 1);

  // One restoring-division step: returns {remainder, shifted dividend with new quotient bit}.
  function automatic logic [2*SUM_W:0] div_step(input logic [SUM_W:0]   rem,
                                                input logic [SUM_W-1:0] dvd,
                                                input logic [SUM_W-1:0] dsr);
    logic [SUM_W:0] sh;
    logic           q;
    sh = {rem[SUM_W-1:0], dvd[SUM_W-1]};
    q  = (sh >= {1'b0, dsr});
    if (q) sh = sh - {1'b0, dsr};
    return {sh, dvd[SUM_W-2:0], q};
  endfunction

  state_t           state_q, state_d;
  logic             de_q, de_d, vs_q, vs_d, hs_q, hs_d, done_q, done_d, valid_q, valid_d;
  logic [23:0]      pix_q, pix_d;
  logic [X_W-1:0]   x_q, x_d, cx_q, cx_d;
  logic [Y_W-1:0]   y_q, y_d, cy_q, cy_d;
  logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_lat_q, cnt_lat_d;
  logic [SUM_W-1:0] dvd_x_q, dvd_x_d, dvd_y_q, dvd_y_d;
  logic [SUM_W:0]   rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             vs_rise, de_fall, hit;
  logic [SUM_W-1:0] divisor;

  always_comb begin
    vs_rise = v_sync_in & ~vs_q;
    de_fall = de_q & ~de_in;
    hit     = de_in && (pixel_in != 24'h0);
    divisor = SUM_W'(cnt_lat_q);

    de_d = de_in;
    vs_d = v_sync_in;
    hs_d = h_sync_in;
    pix_d = (de_in && valid_q && (x_q == cx_q || y_q == cy_q)) ? MARK_COLOR : pixel_in;

    x_d = x_q;
    if (de_in) begin
      if (x_q != X_MAX) x_d = x_q + 1'b1;
    end else if (de_fall) begin
      x_d = '0;
    end

    y_d = y_q;
    if (vs_rise) y_d = '0;
    else if (de_fall && y_q != Y_MAX) y_d = y_q + 1'b1;

    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    cnt_d   = cnt_q;
    if (vs_rise) begin
      sum_x_d = '0;
      sum_y_d = '0;
      cnt_d   = '0;
    end else if (hit) begin
      sum_x_d = sum_x_q + SUM_W'(x_q);
      sum_y_d = sum_y_q + SUM_W'(y_q);
      cnt_d   = cnt_q + 1'b1;
    end

    state_d   = state_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    cnt_lat_d = cnt_lat_q;
    dvd_x_d   = dvd_x_q;
    dvd_y_d   = dvd_y_q;
    rem_x_d   = rem_x_q;
    rem_y_d   = rem_y_q;
    bit_d     = bit_q;
    // Frame-end sync edges arriving while busy leave the latched operands untouched.
    case (state_q)
      IDLE: if (vs_rise) begin
        dvd_x_d   = sum_x_q;
        dvd_y_d   = sum_y_q;
        cnt_lat_d = cnt_q;
        state_d   = CHECK;
      end
      CHECK: begin
        rem_x_d = '0;
        rem_y_d = '0;
        bit_d   = '0;
        state_d = (cnt_lat_q == '0) ? DONE : DIV;
      end
      DIV: begin
        {rem_x_d, dvd_x_d} = div_step(rem_x_q, dvd_x_q, divisor);
        {rem_y_d, dvd_y_d} = div_step(rem_y_q, dvd_y_q, divisor);
        bit_d = bit_q + 1'b1;
        if (bit_q == LAST_BIT) state_d = DONE;
      end
      DONE: begin
        if (cnt_lat_q == '0) begin
          valid_d = 1'b0;
        end else begin
          cx_d    = dvd_x_q[X_W-1:0];
          cy_d    = dvd_y_q[Y_W-1:0];
          valid_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      de_q <= 1'b0; vs_q <= 1'b0; hs_q <= 1'b0; pix_q <= '0;
      done_q <= 1'b0; valid_q <= 1'b0; cx_q <= '0; cy_q <= '0;
      x_q <= '0; y_q <= '0; sum_x_q <= '0; sum_y_q <= '0; cnt_q <= '0;
      cnt_lat_q <= '0; dvd_x_q <= '0; dvd_y_q <= '0;
      rem_x_q <= '0; rem_y_q <= '0; bit_q <= '0;
    end else begin
      state_q <= state_d;
      de_q <= de_d; vs_q <= vs_d; hs_q <= hs_d; pix_q <= pix_d;
      done_q <= done_d; valid_q <= valid_d; cx_q <= cx_d; cy_q <= cy_d;
      x_q <= x_d; y_q <= y_d; sum_x_q <= sum_x_d; sum_y_q <= sum_y_d; cnt_q <= cnt_d;
      cnt_lat_q <= cnt_lat_d; dvd_x_q <= dvd_x_d; dvd_y_q <= dvd_y_d;
      rem_x_q <= rem_x_d; rem_y_q <= rem_y_d; bit_q <= bit_d;
    end
  end

  assign de_out         = de_q;
  assign v_sync_out     = vs_q;
  assign h_sync_out     = hs_q;
  assign pixel_out      = pix_q;
  assign centroid_x     = cx_q;
  assign centroid_y     = cy_q;
  assign centroid_valid = valid_q;
  assign frame_done     = done_q;

endmodule

// File: doc/vp_centroid.md
Name: vp_centroid

Overview:
- Video-path stage directly downstream of binarisation. Consumes the binary RGB stream, where any non-zero pixel is object and 24'h000000 is background.
- Per frame, accumulates the object pixel count and the sums of x and y coordinates.
- At frame end, a multi-cycle sequential divider computes the centroid.
- Passes video through with one cycle of latency and overlays a crosshair at the last valid centroid.

Parameters:
- H_SIZE, 1280, active pixels per line.
- V_SIZE, 720, active lines per frame.
- X_W, 11, width of the x coordinate and centroid_x.
- Y_W, 11, width of the y coordinate and centroid_y.
- SUM_W, 32, width of the coordinate-sum accumulators and the divider.
- CNT_W, 21, width of the object-pixel counter.
- MARK_COLOR, 24'hFF0000, crosshair colour.

Ports:
- clk, in, 1: pixel clock; all logic is on the rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- de_in, in, 1: data enable, high during active pixels.
- v_sync_in, in, 1: vertical sync, active-high.
- h_sync_in, in, 1: horizontal sync, active-high.
- pixel_in, in, 24: binarised pixel.
- de_out, out, 1: de_in delayed 1 cycle.
- v_sync_out, out, 1: v_sync_in delayed 1 cycle.
- h_sync_out, out, 1: h_sync_in delayed 1 cycle.
- pixel_out, out, 24: pixel delayed 1 cycle, with the crosshair overlaid.
- centroid_x, out, X_W: last computed centroid x.
- centroid_y, out, Y_W: last computed centroid y.
- centroid_valid, out, 1: high when the last completed frame had at least one object pixel.
- frame_done, out, 1: one-cycle pulse when the centroid outputs update.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs, counters, accumulators and the FSM clear to 0 / IDLE.
  - pixel_out=0; syncs and de_out are 0.
  - Reset mid-division aborts the division with no frame_done pulse.
- Coordinates:
  - x increments on each cycle with de_in=1 and clears on the de_in falling edge.
  - y increments on each de_in falling edge and clears on the v_sync_in rising edge.
  - Both saturate at H_SIZE-1 and V_SIZE-1.
- Accumulation: on each cycle with de_in=1 and pixel_in!=0:
  - cnt += 1
  - sum_x += x
  - sum_y += y
- Frame end: on a v_sync_in rising edge (detected from a registered copy):
  - Latch sum_x, sum_y and cnt into the divider operands.
  - Clear the accumulators the same cycle; the next frame accumulates in parallel with division.
- FSM states:
  - IDLE: on the v_sync rise, go to CHECK.
  - CHECK: if latched cnt=0, set centroid_valid=0, keep centroid_x/y, pulse frame_done, return to IDLE. Otherwise go to DIV.
  - DIV: two restoring dividers run in parallel, sum_x/cnt and sum_y/cnt, one quotient bit per cycle, SUM_W cycles. Then go to DONE.
  - DONE: register the truncated quotients into centroid_x/y, set centroid_valid=1, pulse frame_done, return to IDLE.
- Latency: frame_done rises SUM_W+2 cycles after the edge that samples the v_sync rise (2 cycles when cnt=0).
- A v_sync rise during CHECK/DIV/DONE is ignored for division; that frame's result is lost, but the accumulators still clear.
- Quotients are always less than H_SIZE and V_SIZE, so truncation to X_W/Y_W is lossless.
- Video pass-through:
  - de, syncs and pixel are registered with exactly 1 cycle latency.
  - pixel_out = MARK_COLOR when de_in=1, centroid_valid=1, and (x==centroid_x or y==centroid_y). Otherwise pixel_out = pixel_in.
  - The comparison uses the centroid registers' values at that cycle; an update mid-frame takes effect immediately.
- Width rule: SUM_W must be at least ceil(log2(H_SIZE·V_SIZE·H_SIZE)); this is the integrator's responsibility.

Test Plan:
- H_SIZE=8, V_SIZE=4, single non-zero pixel at (5,2), then a v_sync rise -> frame_done pulses SUM_W+2 cycles later, centroid=(5,2), centroid_valid=1.
- 2x2 white block at x=10..11, y=20..21 (default sizes) -> centroid=(10,20); checks truncation of 10.5.
- All-black frame following a valid frame at (5,2) -> frame_done after 2 cycles, centroid_valid=0, centroid stays (5,2), no crosshair drawn in the next frame.
- Overlay with centroid=(3,1) on an all-black 8x4 frame -> pixel_out=FF0000 for row 1 and column 3, otherwise 0. de_out/h_sync_out/v_sync_out equal the inputs delayed exactly 1 cycle.
- Full-white 8x4 frame -> cnt=32, sum_x=112, sum_y=48, centroid=(3,1).
- rst_n=0 for one cycle in the middle of DIV -> no frame_done, outputs 0, FSM IDLE. The next full frame produces a correct result.
